// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared state type, kernel constants and helpers for the Sobel stream filter
package sobel_pkg;

  typedef enum logic [1:0] {HDR_RX, HDR_TX, PIX_RX, DRAIN} state_e;

  localparam int HDR_BYTES = 4;
  localparam int K_SIDE    = 1;
  localparam int K_CENTER  = 2;

  function automatic logic [31:0] sobel_abs(input logic signed [31:0] v);
    return v[31] ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two-row line store, one word per column holding {row r-2, row r-1}
module sobel_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rd_en_i,
  input  logic [AW-1:0]       rd_addr_i,
  output logic [2*DATA_W-1:0] rd_data_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i
);

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [2*DATA_W-1:0] rd_data_q;

  // A read and write to the same address in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - framed 3x3 Sobel edge filter with ready/valid streaming
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 640,
  parameter int SHIFT     = 0,
  parameter int THRESHOLD = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  input  logic              mode,
  output logic              error
);

  localparam int GW = DATA_W + 3;
  localparam int AW = $clog2(MAX_WIDTH);
  localparam logic [DATA_W-1:0] PIX_MAX = '1;
  localparam logic [GW-1:0] KS = GW'(K_SIDE);
  localparam logic [GW-1:0] KC = GW'(K_CENTER);

  state_e              state_q;
  logic [1:0]          hb_q;
  logic [15:0]         width_q, height_q, col_q, row_q;
  logic [31:0]         drain_cnt_q;
  logic                mode_q, err_q, done_q;
  logic                s1_valid_q, s1_out_q;
  logic [AW-1:0]       s1_col_q;
  logic [DATA_W-1:0]   s1_pix_q;
  logic [DATA_W-1:0]   win_q [3][2];
  logic [DATA_W-1:0]   data_out_q;
  logic                valid_out_q;

  logic                out_free, in_fire, s1_fire, hdr_bad;
  logic [31:0]         frame_len;
  logic [15:0]         w_m2, h_m2;
  logic [7:0]          tx_byte;
  logic [2*DATA_W-1:0] lb_rd_data;
  logic [DATA_W-1:0]   col_new [3];
  logic [GW-1:0]       x_pos, x_neg, y_pos, y_neg, mag, mag_sh;
  logic signed [GW-1:0] gx, gy;
  logic [DATA_W-1:0]   pix_result;

  assign out_free  = !valid_out_q || ready_out;
  assign ready_in  = !rst && out_free &&
                     (state_q == HDR_RX || state_q == DRAIN || (state_q == PIX_RX && !done_q));
  assign in_fire   = valid_in && ready_in;
  assign s1_fire   = s1_valid_q && (!s1_out_q || out_free);
  assign hdr_bad   = (width_q < 16'd3) || (height_q < 16'd3) || (32'(width_q) > 32'(MAX_WIDTH));
  assign frame_len = 32'(width_q) * 32'(height_q);
  assign w_m2      = width_q - 16'd2;
  assign h_m2      = height_q - 16'd2;

  always_comb begin
    tx_byte = 8'd0;
    if (!hdr_bad) begin
      case (hb_q)
        2'd0: tx_byte = w_m2[7:0];
        2'd1: tx_byte = w_m2[15:8];
        2'd2: tx_byte = h_m2[7:0];
        2'd3: tx_byte = h_m2[15:8];
      endcase
    end
  end

  sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_WIDTH)) u_line_buf (
    .clk       (clk),
    .rd_en_i   (in_fire && state_q == PIX_RX),
    .rd_addr_i (col_q[AW-1:0]),
    .rd_data_o (lb_rd_data),
    .wr_en_i   (s1_fire),
    .wr_addr_i (s1_col_q),
    .wr_data_i ({col_new[1], s1_pix_q})
  );

  // Newest window column: rows r-2 and r-1 from the line store, row r from the pixel stage.
  assign col_new[0] = lb_rd_data[2*DATA_W-1:DATA_W];
  assign col_new[1] = lb_rd_data[DATA_W-1:0];
  assign col_new[2] = s1_pix_q;

  assign x_pos  = KS * GW'(col_new[0]) + KC * GW'(col_new[1]) + KS * GW'(col_new[2]);
  assign x_neg  = KS * GW'(win_q[0][0]) + KC * GW'(win_q[1][0]) + KS * GW'(win_q[2][0]);
  assign y_pos  = KS * GW'(win_q[2][0]) + KC * GW'(win_q[2][1]) + KS * GW'(col_new[2]);
  assign y_neg  = KS * GW'(win_q[0][0]) + KC * GW'(win_q[0][1]) + KS * GW'(col_new[0]);
  assign gx     = $signed(x_pos - x_neg);
  assign gy     = $signed(y_pos - y_neg);
  assign mag    = GW'(sobel_abs(32'(gx)) + sobel_abs(32'(gy)));
  assign mag_sh = mag >> SHIFT;
  assign pix_result = mode_q ? ((mag_sh >= GW'(THRESHOLD)) ? PIX_MAX : '0)
                             : ((mag_sh > GW'(PIX_MAX)) ? PIX_MAX : mag_sh[DATA_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR_RX;
      hb_q        <= 2'd0;
      width_q     <= 16'd0;
      height_q    <= 16'd0;
      col_q       <= 16'd0;
      row_q       <= 16'd0;
      drain_cnt_q <= 32'd0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_out_q    <= 1'b0;
      s1_col_q    <= '0;
      s1_pix_q    <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      if (valid_out_q && ready_out) valid_out_q <= 1'b0;
      if (s1_fire) begin
        s1_valid_q <= 1'b0;
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= col_new[r];
        end
        if (s1_out_q) begin
          data_out_q  <= pix_result;
          valid_out_q <= 1'b1;
        end
      end
      case (state_q)
        HDR_RX: if (in_fire) begin
          hb_q <= hb_q + 2'd1;
          case (hb_q)
            2'd0: begin width_q[7:0] <= data_in[7:0]; mode_q <= mode; err_q <= 1'b0; end
            2'd1: width_q[15:8]  <= data_in[7:0];
            2'd2: height_q[7:0]  <= data_in[7:0];
            2'd3: height_q[15:8] <= data_in[7:0];
          endcase
          if (hb_q == 2'(HDR_BYTES - 1)) state_q <= HDR_TX;
        end
        HDR_TX: if (out_free) begin
          data_out_q  <= DATA_W'(tx_byte);
          valid_out_q <= 1'b1;
          hb_q        <= hb_q + 2'd1;
          if (hb_q == 2'(HDR_BYTES - 1)) begin
            col_q       <= 16'd0;
            row_q       <= 16'd0;
            done_q      <= 1'b0;
            drain_cnt_q <= 32'd0;
            if (hdr_bad) begin
              err_q   <= 1'b1;
              state_q <= (frame_len == 32'd0) ? HDR_RX : DRAIN;
            end else begin
              state_q <= PIX_RX;
            end
          end
        end
        PIX_RX: begin
          if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_pix_q   <= data_in;
            s1_col_q   <= col_q[AW-1:0];
            s1_out_q   <= (row_q >= 16'd2) && (col_q >= 16'd2);
            if (col_q == width_q - 16'd1) begin
              col_q <= 16'd0;
              row_q <= row_q + 16'd1;
              if (row_q == height_q - 16'd1) done_q <= 1'b1;
            end else begin
              col_q <= col_q + 16'd1;
            end
          end
          // Leave only once the final result has left the output register.
          if (done_q && !s1_valid_q && out_free) state_q <= HDR_RX;
        end
        DRAIN: if (in_fire) begin
          drain_cnt_q <= drain_cnt_q + 32'd1;
          if (drain_cnt_q == frame_len - 32'd1) state_q <= HDR_RX;
        end
        default: state_q <= HDR_RX;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign error     = err_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb/tb_sobel_stream_filter.sv - self-checking bench for sobel_stream_filter
module tb_sobel_stream_filter;

  localparam int DW    = 8;
  localparam int MAXW  = 8;
  localparam int SH    = 0;
  localparam int THR_A = 40;
  localparam int THR_B = 49;
  localparam int PMAX  = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst, valid_in, ready_out, mode;
  logic [DW-1:0] data_in;
  logic          ready_in_a, valid_out_a, error_a;
  logic          ready_in_b, valid_out_b, error_b;
  logic [DW-1:0] data_out_a, data_out_b;

  int tests = 0;
  int fails = 0;
  int pix[$];
  int exp_a[$], exp_b[$], got_a[$], got_b[$];
  bit bp_en = 1'b0;

  always #5 clk = ~clk;

  sobel_stream_filter #(.DATA_W(DW), .MAX_WIDTH(MAXW), .SHIFT(SH), .THRESHOLD(THR_A)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in_a),
    .data_out(data_out_a), .valid_out(valid_out_a), .ready_out(ready_out), .mode(mode), .error(error_a)
  );

  sobel_stream_filter #(.DATA_W(DW), .MAX_WIDTH(MAXW), .SHIFT(SH), .THRESHOLD(THR_B)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in_b),
    .data_out(data_out_b), .valid_out(valid_out_b), .ready_out(ready_out), .mode(mode), .error(error_b)
  );

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Output collector; a stalled byte must stay put until accepted.
  initial begin
    logic          pv;
    logic [DW-1:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          tests++;
          assert (valid_out_a === 1'b1 && data_out_a === pd) else begin
            fails++;
            $error("FAIL stall_hold got v=%b d=%0d expected v=1 d=%0d", valid_out_a, data_out_a, pd);
          end
        end
        if (valid_out_a && ready_out) got_a.push_back(int'(data_out_a));
        if (valid_out_b && ready_out) got_b.push_back(int'(data_out_b));
        pv = valid_out_a && !ready_out;
        pd = data_out_a;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int w, input int h, input int kind);
    pix.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (kind)
          0: pix.push_back(r * w + c);
          1: pix.push_back(200);
          2: pix.push_back((((r >> 1) + (c >> 1)) & 1) != 0 ? PMAX : 0);
          default: pix.push_back($urandom_range(0, PMAX));
        endcase
  endtask

  function automatic int sat(input int m, input bit md, input int thr);
    if (md) return (m >= thr) ? PMAX : 0;
    return (m > PMAX) ? PMAX : m;
  endfunction

  // Reference: direct 2-D convolution over the whole frame held in pix.
  task automatic expect_frame(input int w, input int h, input bit md);
    int hdr[4];
    if (w < 3 || h < 3 || w > MAXW) begin
      repeat (4) begin exp_a.push_back(0); exp_b.push_back(0); end
      return;
    end
    hdr = '{(w - 2) % 256, (w - 2) / 256, (h - 2) % 256, (h - 2) / 256};
    foreach (hdr[i]) begin exp_a.push_back(hdr[i]); exp_b.push_back(hdr[i]); end
    for (int r = 1; r < h - 1; r++)
      for (int c = 1; c < w - 1; c++) begin
        int gx = 0;
        int gy = 0;
        int m;
        for (int d = -1; d <= 1; d++) begin
          int k = (d == 0) ? 2 : 1;
          gx += k * (pix[(r + d) * w + c + 1] - pix[(r + d) * w + c - 1]);
          gy += k * (pix[(r + 1) * w + c + d] - pix[(r - 1) * w + c + d]);
        end
        m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> SH;
        exp_a.push_back(sat(m, md, THR_A));
        exp_b.push_back(sat(m, md, THR_B));
      end
  endtask

  task automatic send_byte(input int b);
    int n = 0;
    if (bp_en && $urandom_range(0, 3) == 0) @(negedge clk);
    data_in  = DW'(b);
    valid_in = 1'b1;
    while (ready_in_a !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_within_bound", {31'd0, ready_in_a}, 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // mode flips after the first header byte to show it is sampled only there.
  task automatic send_frame(input int w, input int h, input bit md);
    mode = md;
    send_byte(w % 256);
    mode = !md;
    send_byte(w / 256);
    send_byte(h % 256);
    send_byte(h / 256);
    foreach (pix[i]) send_byte(pix[i]);
  endtask

  task automatic check_out(input string tag, input bit err_exp);
    int n = 0;
    while ((got_a.size() < exp_a.size() || got_b.size() < exp_b.size()) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk($sformatf("%s_len_a", tag), got_a.size(), exp_a.size());
    chk($sformatf("%s_len_b", tag), got_b.size(), exp_b.size());
    foreach (exp_a[i]) if (i < got_a.size()) chk($sformatf("%s_a[%0d]", tag, i), got_a[i], exp_a[i]);
    foreach (exp_b[i]) if (i < got_b.size()) chk($sformatf("%s_b[%0d]", tag, i), got_b[i], exp_b[i]);
    chk($sformatf("%s_error", tag), {31'd0, error_a}, {31'd0, err_exp});
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic frame(input string tag, input int w, input int h, input int kind, input bit md, input bit err_exp);
    fill(w, h, kind);
    expect_frame(w, h, md);
    send_frame(w, h, md);
    check_out(tag, err_exp);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", {31'd0, valid_out_a}, 32'd0);
    chk("rst_data_out", {24'd0, data_out_a}, 32'd0);
    chk("rst_ready_in", {31'd0, ready_in_a}, 32'd0);
    chk("rst_error", {31'd0, error_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready_in", {31'd0, ready_in_a}, 32'd1);

    frame("ramp_m0", 5, 8, 0, 1'b0, 1'b0);
    frame("ramp_m1", 5, 8, 0, 1'b1, 1'b0);
    frame("const", 4, 4, 1, 1'b0, 1'b0);
    frame("checker", 6, 5, 2, 1'b0, 1'b0);

    bp_en = 1'b1;
    frame("ramp_bp", 5, 8, 0, 1'b0, 1'b0);
    bp_en = 1'b0;

    frame("bad_narrow", 2, 8, 3, 1'b0, 1'b1);
    frame("after_bad", 5, 8, 0, 1'b0, 1'b0);

    bp_en = 1'b1;
    frame("bad_wide", 9, 3, 3, 1'b0, 1'b1);
    frame("max_width", 8, 5, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      frame($sformatf("rand%0d", i), $urandom_range(3, MAXW), $urandom_range(3, 6), 3, 1'($urandom_range(0, 1)), 1'b0);

    fill(6, 4, 3); expect_frame(6, 4, 1'b0); send_frame(6, 4, 1'b0);
    fill(3, 3, 3); expect_frame(3, 3, 1'b1); send_frame(3, 3, 1'b1);
    check_out("back_to_back", 1'b0);
    bp_en = 1'b0;

    fill(5, 8, 0);
    mode = 1'b0;
    send_byte(5); send_byte(0); send_byte(8); send_byte(0);
    for (int i = 0; i < 20; i++) send_byte(pix[i]);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_valid_out", {31'd0, valid_out_a}, 32'd0);
    chk("midreset_ready_in", {31'd0, ready_in_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    frame("after_reset", 5, 8, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
